alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Registered operand stage directly upstream of the ALU and its bitwise submodules (AND, OR, etc.).
- Accepts an operand pair plus ALU opcode from the decode/register-read side over a valid/ready handshake.
- Presents the pair and opcode to the ALU from flops, so ALU input timing is isolated from decode logic.
- Internally a 2-entry skid buffer: full throughput, with in_ready driven from a flop (no combinational ready path through the stage).

Parameters:
- WIDTH, 32, operand width in bits for X and Y.
- OP_WIDTH, 4, ALU opcode width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream has a transaction.
- in_ready  output  1  stage can accept; driven directly from a flop.
- in_x  input  WIDTH  operand X.
- in_y  input  WIDTH  operand Y.
- in_op  input  OP_WIDTH  ALU opcode.
- out_valid  output  1  ALU-side transaction present.
- out_ready  input  1  ALU/result side consumes.
- out_x  output  WIDTH  registered operand X to ALU.
- out_y  output  WIDTH  registered operand Y to ALU.
- out_op  output  OP_WIDTH  registered opcode to ALU.

Behaviour:
- Reset and clock:
  - One clock, clk. Reset is asynchronous and active-low, rst_n.
  - While rst_n=0: out_valid=0, in_ready=0, out_x/out_y/out_op=0, skid entry cleared, state=EMPTY.
  - First cycle after rst_n deasserts: in_ready=1.
- Handshake rules:
  - Accept occurs when in_valid&in_ready at a rising edge.
  - Consume occurs when out_valid&out_ready at a rising edge.
  - Upstream must hold in_* stable while in_valid=1 and in_ready=0.
  - Stage holds out_* stable while out_valid=1 and out_ready=0.
- Storage:
  - Main register drives out_* directly.
  - Skid register holds one overflow entry.
- State machine:
  - EMPTY (out_valid=0, in_ready=1):
    - accept -> ONE; load main.
  - ONE (out_valid=1, in_ready=1):
    - accept & consume -> ONE; main loaded with new data.
    - accept & !consume -> TWO; new data to skid.
    - consume & !accept -> EMPTY.
    - neither -> ONE.
  - TWO (out_valid=1, in_ready=0):
    - consume -> ONE; skid moves to main.
    - no consume -> TWO.
    - No accept is possible in TWO.
- Latency: 1 cycle from accept to out_valid when the stage was EMPTY.
- Throughput: one transaction per cycle when out_ready is held at 1.
- Ordering: strict FIFO; no transaction is dropped or duplicated.
- flush:
  - flush=1 at an edge -> next state EMPTY, out_valid=0, in_ready=1.
  - Any accept or consume in the same cycle is ignored (no data captured).
  - flush has priority over all other events.
  - Data registers need not clear on flush.
- Width rules:
  - All data is passed through bit-exact; no arithmetic, extension or truncation.
  - out_op width equals OP_WIDTH.
- Reset mid-operation: reset in any state immediately (asynchronously) forces the reset values above; buffered entries are lost.
- in_ready must never depend combinationally on out_ready.

Test Plan:
- Reset, then 3 back-to-back transactions (X=0xFFFF0000, Y=0x0F0F0F0F, op=0x0; X=1, Y=3, op=0x1; X=0xA5A5A5A5, Y=0xFFFFFFFF, op=0x0) with out_ready=1 -> out_* matches each in the order sent, one cycle after accept; out_valid stays 1 for 3 consecutive cycles; the ALU AND result for the first transaction is 0x0F0F0000.
- Backpressure: out_ready=0, send A=(0x11,0x22,2) then B=(0x33,0x44,3) -> after B in_ready=0 and out_*=A held; raise out_ready -> A then B on consecutive cycles, in_ready returns to 1.
- Simultaneous accept+consume in ONE with a continuous stream of 16 incrementing X values -> no stall, in_ready stays 1, outputs are 0..15 in order.
- flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flush-cycle input is not captured; the next accepted X=0x5 appears as first output.
- Assert rst_n=0 asynchronously mid-cycle while in TWO -> out_valid and in_ready go 0 immediately, out_* reads 0; after release, a new transaction passes with 1-cycle latency.
- Random valid/ready stimulus over 10k cycles against a FIFO scoreboard -> zero mismatches, and in_ready never toggles in the same cycle as an out_ready change without a clock edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Registered operand stage in front of the ALU: a two-entry skid buffer that
// hands X, Y and the opcode to the ALU from flops, with in_ready driven by a flop.
//
// state | meaning
// EMPTY | nothing buffered; out_valid=0, in_ready=1
// ONE   | main register holds the head; out_valid=1, in_ready=1
// TWO   | main and skid both hold entries; out_valid=1, in_ready=0
module alu_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_x,
  input  logic [WIDTH-1:0]    in_y,
  input  logic [OP_WIDTH-1:0] in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_x,
  output logic [WIDTH-1:0]    out_y,
  output logic [OP_WIDTH-1:0] out_op
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;

  logic                accept;
  logic                consume;
  logic                load_main_in;
  logic                load_main_skid;
  logic                load_skid;
  logic [WIDTH-1:0]    skid_x;
  logic [WIDTH-1:0]    skid_y;
  logic [OP_WIDTH-1:0] skid_op;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs are registered from the next state so neither one
  // has a combinational path from the opposite side of the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != TWO);
      out_valid <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_x   <= '0;
      out_y   <= '0;
      out_op  <= '0;
      skid_x  <= '0;
      skid_y  <= '0;
      skid_op <= '0;
    end else begin
      if (load_main_in) begin
        out_x  <= in_x;
        out_y  <= in_y;
        out_op <= in_op;
      end else if (load_main_skid) begin
        out_x  <= skid_x;
        out_y  <= skid_y;
        out_op <= skid_op;
      end
      if (load_skid) begin
        skid_x  <= in_x;
        skid_y  <= in_y;
        skid_op <= in_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_operand_stage;
  localparam int W  = 32;
  localparam int OW = 4;

  typedef struct packed {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [OW-1:0] op;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_y = '0;
  logic [OW-1:0] in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_x;
  logic [W-1:0]  out_y;
  logic [OW-1:0] out_op;

  int n_chk  = 0;
  int n_fail = 0;

  alu_operand_stage #(.WIDTH(W), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_op(out_op)
  );

  always #5 clk = ~clk;

  // Reference model: the stage is a FIFO of depth two.
  txn_t q[$];
  logic mdl_rdy  = 1'b0;
  logic last_acc = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mdl_rdy  = 1'b0;
      last_acc = 1'b0;
    end else if (flush) begin
      q.delete();
      mdl_rdy  = 1'b1;
      last_acc = 1'b0;
    end else begin
      logic acc, con;
      acc = in_valid && mdl_rdy;
      con = out_ready && (q.size() > 0);
      if (con) void'(q.pop_front());
      if (acc) q.push_back('{x: in_x, y: in_y, op: in_op});
      mdl_rdy  = (q.size() < 2);
      last_acc = acc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("cyc_in_ready", 64'(in_ready), 64'(mdl_rdy));
    if (q.size() > 0) begin
      chk("cyc_out_x", 64'(out_x), 64'(q[0].x));
      chk("cyc_out_y", 64'(out_y), 64'(q[0].y));
      chk("cyc_out_op", 64'(out_op), 64'(q[0].op));
    end else if (!rst_n) begin
      chk("cyc_rst_data", {out_x, out_y}, 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic [OW-1:0] op);
    in_valid = v;
    in_x = x;
    in_y = y;
    in_op = op;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_data", {out_x, out_y}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 4'h0);
    tick();
    chk("b2b_t1_x", 64'(out_x), 64'hFFFF0000);
    chk("b2b_t1_and", 64'(out_x & out_y), 64'h0F0F0000);
    chk("b2b_t1_valid", 64'(out_valid), 64'h1);
    drive(1'b1, 32'h1, 32'h3, 4'h1);
    tick();
    chk("b2b_t2_xyop", {out_x[15:0], out_y[15:0], 28'h0, out_op}, {16'h1, 16'h3, 32'h1});
    chk("b2b_t2_valid", 64'(out_valid), 64'h1);
    drive(1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF, 4'h0);
    tick();
    chk("b2b_t3_x", 64'(out_x), 64'hA5A5A5A5);
    chk("b2b_t3_valid", 64'(out_valid), 64'h1);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("b2b_drain", 64'(out_valid), 64'h0);

    // Backpressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h22, 4'h2);
    tick();
    drive(1'b1, 32'h33, 32'h44, 4'h3);
    tick();
    chk("bp_in_ready_low", 64'(in_ready), 64'h0);
    chk("bp_hold_a", {out_x, out_y}, {32'h11, 32'h22});
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bp_still_a", 64'(out_op), 64'h2);
    out_ready = 1'b1;
    tick();
    chk("bp_b_out", {out_x, out_y}, {32'h33, 32'h44});
    chk("bp_in_ready_back", 64'(in_ready), 64'h1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'h0);

    // Streaming: simultaneous accept and consume
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i), 32'(i + 100), 4'(i));
      tick();
      chk("stream_ready", 64'(in_ready), 64'h1);
      chk("stream_x", 64'(out_x), 64'(i));
    end
    drive(1'b0, '0, '0, '0);
    tick();

    // Flush while full with a transaction offered
    out_ready = 1'b0;
    drive(1'b1, 32'hAA, 32'hBB, 4'h4);
    tick();
    drive(1'b1, 32'hCC, 32'hDD, 4'h5);
    tick();
    drive(1'b1, 32'h99, 32'h98, 4'h6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_ready", 64'(in_ready), 64'h1);
    drive(1'b1, 32'h5, 32'h6, 4'h7);
    tick();
    chk("flush_next_x", 64'(out_x), 64'h5);
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(1'b1, 32'h123, 32'h456, 4'h8);
    tick();
    drive(1'b1, 32'h789, 32'hABC, 4'h9);
    tick();
    drive(1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_ready", 64'(in_ready), 64'h0);
    chk("arst_data", {out_x, out_y}, 64'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("arst_rel_ready", 64'(in_ready), 64'h1);
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD, 32'hBEEF, 4'hA);
    tick();
    chk("arst_lat", {out_valid, 31'h0, out_x}, {1'b1, 31'h0, 32'hDEAD});
    drive(1'b0, '0, '0, '0);
    tick();

    // Random traffic; the model and the negedge checker do the scoring
    for (int c = 0; c < 10000; c++) begin
      if (!(in_valid && !last_acc) || flush)
        drive(($urandom_range(0, 3) != 0), $urandom, $urandom, 4'($urandom));
      flush = ($urandom_range(0, 63) == 0);
      #2 out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rand_ready_indep", 64'(in_ready), 64'(mdl_rdy));
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
